multi_immediate_reader: RTL and testbench

Parametrised next-generation immediate fetcher for the instruction path. It pops a run-time-selected number of little-endian bytes, from 0 to MAX_BYTES, out of the instruction byte FIFO. It assembles them into a zero- or sign-extended immediate and signals completion. It also supports a mid-read flush so the front end can abandon an immediate on a pipeline redirect. It serves the ModRM decoder, displacement fetch and instruction immediates.

---
 rtl/multi_immediate_reader.sv | 151 +++++++++++++++
 tb/tb_multi_immediate_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_immediate_reader.sv
// Immediate fetcher: pops 0..MAX_BYTES little-endian bytes from the instruction
// byte FIFO and assembles a zero- or sign-extended immediate, with mid-read flush.
module multi_immediate_reader #(
    parameter int unsigned MAX_BYTES = 4,
    localparam int unsigned OUT_WIDTH = 8 * MAX_BYTES,
    localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 sign_extend,
    input  logic                 flush,
    output logic                 busy,
    output logic                 complete,
    output logic [OUT_WIDTH-1:0] immediate,
    output logic                 fifo_rd_en,
    input  logic [7:0]           fifo_rd_data,
    input  logic                 fifo_empty
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [LEN_W-1:0]     len_clamped;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt;
    logic                 sign_q;
    logic [OUT_WIDTH-1:0] shadow;
    logic [OUT_WIDTH-1:0] shadow_next;
    logic [OUT_WIDTH-1:0] assembled;
    logic                 sign_bit;
    logic                 accept;
    logic                 zero_len;
    logic                 pop;
    logic                 last_pop;

    // Requests longer than the widest immediate are clamped to MAX_BYTES
    always_comb begin
        len_clamped = len;
        if (len > LEN_W'(MAX_BYTES)) begin
            len_clamped = LEN_W'(MAX_BYTES);
        end
    end

    // Next-state and pop control; flush and reset both suppress the pop
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_len   = 1'b0;
        pop        = 1'b0;
        last_pop   = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (len == '0) begin
                        zero_len = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    fifo_rd_en = 1'b1;
                    if (cnt == LEN_W'(len_q - LEN_W'(1))) begin
                        last_pop   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            fifo_rd_en = 1'b0;
            pop        = 1'b0;
            last_pop   = 1'b0;
        end
    end

    // Drop the popped byte into its lane and build the extended result
    always_comb begin
        shadow_next = shadow;
        sign_bit    = 1'b0;
        assembled   = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (pop && (cnt == LEN_W'(i))) begin
                shadow_next[8*i +: 8] = fifo_rd_data;
            end
        end
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (LEN_W'(i + 1) == len_q) begin
                sign_bit = shadow_next[8*i + 7];
            end
        end
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (LEN_W'(i) < len_q) begin
                assembled[8*i +: 8] = shadow_next[8*i +: 8];
            end else begin
                assembled[8*i +: 8] = {8{sign_q & sign_bit}};
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched request, working shadow and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            complete  <= 1'b0;
            immediate <= '0;
            cnt       <= '0;
            len_q     <= '0;
            sign_q    <= 1'b0;
            shadow    <= '0;
        end else begin
            busy     <= (state_next == READ);
            complete <= zero_len | last_pop;
            if (accept) begin
                len_q  <= len_clamped;
                sign_q <= sign_extend;
                cnt    <= '0;
                shadow <= '0;
            end else if (pop) begin
                shadow <= shadow_next;
                cnt    <= cnt + LEN_W'(1);
            end
            if (zero_len) begin
                immediate <= '0;
            end else if (last_pop) begin
                immediate <= assembled;
            end
        end
    end

endmodule

// File: tb/tb_multi_immediate_reader.sv
// Self-checking bench for multi_immediate_reader (MAX_BYTES=4) with a byte-queue
// FIFO, a transaction-level reference model and directed scenarios.
module tb_multi_immediate_reader;

    localparam int unsigned MAXB = 4;
    localparam int unsigned LW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          sign_extend;
    logic          flush;
    logic          busy;
    logic          complete;
    logic [31:0]   immediate;
    logic          fifo_rd_en;
    logic [7:0]    fifo_rd_data;
    logic          fifo_empty;

    int errors = 0;
    int checks = 0;
    int edges = 0;
    int pops = 0;
    int comps = 0;
    int comp_edge = 0;
    int st_edge = 0;
    int p0;
    int c0;

    logic [7:0]  fq[$];
    bit          m_reading = 1'b0;
    int          m_len = 0;
    bit          m_sx = 1'b0;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_imm = '0;

    multi_immediate_reader #(.MAX_BYTES(MAXB)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .sign_extend  (sign_extend),
        .flush        (flush),
        .busy         (busy),
        .complete     (complete),
        .immediate    (immediate),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // Value of the gathered bytes, little-endian, extended from the top byte
    function automatic logic [31:0] assemble();
        logic [31:0] v = '0;
        int n = m_bytes.size();
        for (int i = 0; i < n; i++) v = v | (32'(m_bytes[i]) << (8 * i));
        if (m_sx && m_bytes[n-1][7] && n < 4) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // One clock: sample inputs, check pop, clock, update FIFO and model, compare
    task automatic step();
        logic          s_start, s_flush, s_reset, s_sx, s_empty, s_rd;
        logic [7:0]    s_data;
        logic [LW-1:0] s_len;
        bit            exp_rd;
        bit            exp_comp;
        int            eff;
        #2;
        s_start = start;  s_flush = flush;  s_reset = reset;  s_sx = sign_extend;
        s_empty = fifo_empty;  s_data = fifo_rd_data;  s_len = len;  s_rd = fifo_rd_en;
        exp_rd = m_reading && !s_empty && !s_flush && !s_reset;
        chk("fifo_rd_en", 64'(s_rd), 64'(exp_rd));
        @(posedge clk);
        #1;
        edges++;
        if (s_rd === 1'b1) begin
            void'(fq.pop_front());
            pops++;
        end
        fifo_refresh();
        exp_comp = 1'b0;
        if (s_reset) begin
            m_reading = 1'b0;
            m_imm     = '0;
        end else if (m_reading) begin
            if (s_flush) begin
                m_reading = 1'b0;
            end else if (!s_empty) begin
                m_bytes.push_back(s_data);
                if (m_bytes.size() == m_len) begin
                    m_imm     = assemble();
                    m_reading = 1'b0;
                    exp_comp  = 1'b1;
                end
            end
        end else if (s_start && !s_flush) begin
            eff = (int'(s_len) > int'(MAXB)) ? int'(MAXB) : int'(s_len);
            if (eff == 0) begin
                m_imm    = '0;
                exp_comp = 1'b1;
            end else begin
                m_reading = 1'b1;
                m_len     = eff;
                m_sx      = s_sx;
                m_bytes.delete();
            end
        end
        chk("busy", 64'(busy), 64'(m_reading));
        chk("complete", 64'(complete), 64'(exp_comp));
        chk("immediate", 64'(immediate), 64'(m_imm));
        if (complete === 1'b1) begin
            comps++;
            comp_edge = edges;
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input int l, input bit sx);
        start       = 1'b1;
        len         = LW'(l);
        sign_extend = sx;
        st_edge     = edges + 1;
        step();
        start = 1'b0;
    endtask

    task automatic load(input logic [7:0] b);
        fq.push_back(b);
        fifo_refresh();
    endtask

    task automatic drain();
        fq.delete();
        fifo_refresh();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; sign_extend = 1'b0; flush = 1'b0;
        fifo_refresh();
        @(posedge clk);
        @(negedge clk);
        steps(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_complete", 64'(complete), 64'd0);
        chk("rst_immediate", 64'(immediate), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        reset = 1'b0;
        step();

        // len=1 sign-extended 0x80
        p0 = pops;
        load(8'h80);
        issue(1, 1'b1);
        steps(3);
        chk("t1_pops", 64'(pops - p0), 64'd1);
        chk("t1_cycle", 64'(comp_edge - st_edge + 1), 64'd2);
        chk("t1_imm", 64'(immediate), 64'hFFFF_FF80);

        // len=2 zero-extended, leftover byte untouched
        p0 = pops;
        load(8'h34); load(8'h12); load(8'hEE);
        issue(2, 1'b0);
        steps(4);
        chk("t2_pops", 64'(pops - p0), 64'd2);
        chk("t2_cycle", 64'(comp_edge - st_edge + 1), 64'd3);
        chk("t2_imm", 64'(immediate), 64'h0000_1234);
        chk("t2_left", 64'(fq.size()), 64'd1);
        chk("t2_left_byte", 64'(fq[0]), 64'hEE);
        drain();

        // len=4 with a three-cycle empty gap
        p0 = pops;
        load(8'h12);
        issue(4, 1'b0);
        steps(4);
        load(8'h34); load(8'h56); load(8'h78);
        steps(5);
        chk("t3_pops", 64'(pops - p0), 64'd4);
        chk("t3_cycle", 64'(comp_edge - st_edge + 1), 64'd8);
        chk("t3_imm", 64'(immediate), 64'h7856_3412);

        // flush after two pops keeps the previous immediate
        load(8'hCD); load(8'hAB);
        issue(2, 1'b0);
        steps(3);
        chk("t4_prior", 64'(immediate), 64'h0000_ABCD);
        p0 = pops;
        c0 = comps;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        issue(4, 1'b0);
        steps(2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_busy_drop", 64'(busy), 64'd0);
        chk("t4_pops", 64'(pops - p0), 64'd2);
        steps(2);
        chk("t4_no_complete", 64'(comps - c0), 64'd0);
        chk("t4_imm_kept", 64'(immediate), 64'h0000_ABCD);
        drain();
        load(8'h01); load(8'h02);
        issue(2, 1'b0);
        steps(4);
        chk("t4_next_imm", 64'(immediate), 64'h0000_0201);

        // len=0, then start while busy is ignored
        p0 = pops;
        issue(0, 1'b1);
        steps(2);
        chk("t5_zero_pops", 64'(pops - p0), 64'd0);
        chk("t5_zero_cycle", 64'(comp_edge - st_edge + 1), 64'd1);
        chk("t5_zero_imm", 64'(immediate), 64'd0);
        p0 = pops;
        load(8'hAA); load(8'hBB); load(8'hCC); load(8'hDD);
        issue(3, 1'b1);
        start = 1'b1;
        len   = LW'(1);
        step();
        start = 1'b0;
        steps(4);
        chk("t5_pops", 64'(pops - p0), 64'd3);
        chk("t5_cycle", 64'(comp_edge - st_edge + 1), 64'd4);
        chk("t5_imm", 64'(immediate), 64'hFFCC_BBAA);
        drain();

        // reset in cycle 2 of a len=4 read
        c0 = comps;
        load(8'h01); load(8'h02); load(8'h03); load(8'h04);
        issue(4, 1'b0);
        reset = 1'b1;
        step();
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("t6_imm", 64'(immediate), 64'd0);
        chk("t6_no_complete", 64'(comps - c0), 64'd0);
        reset = 1'b0;
        drain();
        load(8'h5A);
        issue(1, 1'b0);
        steps(3);
        chk("t6_next_imm", 64'(immediate), 64'h0000_005A);

        // over-length request clamps to four bytes
        p0 = pops;
        load(8'h01); load(8'h02); load(8'h03); load(8'h84); load(8'h99);
        issue(7, 1'b1);
        steps(5);
        chk("t7_pops", 64'(pops - p0), 64'd4);
        chk("t7_cycle", 64'(comp_edge - st_edge + 1), 64'd5);
        chk("t7_imm", 64'(immediate), 64'h8403_0201);
        drain();

        // two-byte sign extension
        load(8'h00); load(8'h80);
        issue(2, 1'b1);
        steps(4);
        chk("t8_imm", 64'(immediate), 64'hFFFF_8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
